// File: rtl/mod12_pkg.sv
// Shared constants and state type for the mod-12 up/down timer family.
package mod12_pkg;

  localparam int MOD = 12;
  localparam int MAX = MOD - 1;
  localparam int W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mod12_down_timer.sv
// Loadable mod-MOD down-counter/timer with terminal-count pulse and
// optional auto-reload. A load of MOD-1 with auto_reload gives a
// free-running mod-MOD down counter.
//
//   state | meaning
//   ------+--------------------------------------------------------
//   IDLE  | after reset, waiting for the first load
//   RUN   | counting down on enabled edges; tc at the zero edge
//   DONE  | one-shot finished, count parked at 0 until next load
module mod12_down_timer
  import mod12_pkg::*;
#(
  parameter int MOD = mod12_pkg::MOD,
  parameter int W   = mod12_pkg::W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  input  logic         load,
  input  logic         en,
  input  logic         auto_reload,
  output logic [W-1:0] count,
  output logic         tc,
  output logic         busy,
  output logic         done
);

  localparam logic [W-1:0] MAX_CNT = W'(MOD - 1);

  state_t       state_q, state_d;
  logic [W-1:0] count_q, count_d;
  logic [W-1:0] reload_q, reload_d;
  logic         tc_q, tc_d;
  logic [W-1:0] din_sat;

  // Out-of-range load values clamp to the largest legal count.
  assign din_sat = (din > MAX_CNT) ? MAX_CNT : din;

  // State, count, reload value and terminal-count registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
    end
  end

  // Next-state logic: load always wins, so a load on the terminal edge
  // suppresses tc and the move to DONE.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    tc_d     = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (load) begin
          count_d  = din_sat;
          reload_d = din_sat;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (load) begin
          count_d  = din_sat;
          reload_d = din_sat;
        end else if (en) begin
          if (count_q != '0) begin
            count_d = count_q - W'(1);
          end else begin
            tc_d = 1'b1;
            if (auto_reload) begin
              count_d = reload_q;
            end else begin
              state_d = DONE;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign busy  = (state_q == RUN);
  assign done  = (state_q == DONE);

endmodule
